// File: rtl/huff_pair_decoder.sv
// Bit-serial Huffman pair decoder for the MP3 big_values region.
// The codebook lookup is external; this block walks codeword, linbits and sign bits per pair.
module huff_pair_decoder #(
  parameter int MAX_BITS    = 19,
  parameter int MAX_LINBITS = 13,
  parameter int OUT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [9:0]              num_pairs,
  input  logic [3:0]              linbits,
  input  logic                    axiiv,
  input  logic                    axiid,
  output logic                    axiir,
  output logic [MAX_BITS-1:0]     lut_bits,
  output logic [4:0]              lut_len,
  input  logic                    lut_found,
  input  logic [3:0]              lut_x,
  input  logic [3:0]              lut_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] x_val,
  output logic signed [OUT_W-1:0] y_val,
  output logic                    done,
  output logic                    err,
  output logic                    busy
);

  localparam int MAG_W = MAX_LINBITS + 1;

  typedef enum logic [2:0] {IDLE, CODE, XLIN, XSIGN, YLIN, YSIGN, EMIT, ERR} state_t;

  state_t                 state_reg;
  logic [9:0]             pairs_left_reg;
  logic [3:0]             lin_reg;
  logic [3:0]             cnt_reg;
  logic [MAX_LINBITS-1:0] lin_acc_reg;
  logic [MAG_W-1:0]       x_mag_reg;
  logic [MAG_W-1:0]       y_mag_reg;
  logic                   x_neg_reg;

  logic                   matched;
  logic                   overrun;
  logic                   take;
  state_t                 code_route;
  state_t                 sign_route;
  logic [MAX_LINBITS-1:0] lin_shift;
  logic [MAG_W-1:0]       lin_mag;

  function automatic state_t route_y(input logic [3:0] m, input logic [3:0] l);
    if (m == 4'd15 && l != 4'd0) return YLIN;
    else if (m != 4'd0)          return YSIGN;
    else                         return EMIT;
  endfunction

  function automatic state_t route_x(input logic [3:0] mx, input logic [3:0] my, input logic [3:0] l);
    if (mx == 4'd15 && l != 4'd0) return XLIN;
    else if (mx != 4'd0)          return XSIGN;
    else                          return route_y(my, l);
  endfunction

  function automatic logic signed [OUT_W-1:0] to_val(input logic [MAG_W-1:0] mag, input logic neg);
    logic signed [OUT_W-1:0] v;
    v = OUT_W'(mag);
    return neg ? -v : v;
  endfunction

  // The lookup is ignored until at least one bit has been collected.
  assign matched    = (state_reg == CODE) && (lut_len != 5'd0) && lut_found;
  assign overrun    = (state_reg == CODE) && !matched && (lut_len == 5'(MAX_BITS));
  assign take       = axiiv && axiir;
  assign code_route = route_x(lut_x, lut_y, lin_reg);
  assign sign_route = route_y(y_mag_reg[3:0], lin_reg);
  assign lin_shift  = {lin_acc_reg[MAX_LINBITS-2:0], axiid};
  assign lin_mag    = MAG_W'(15) + MAG_W'(lin_shift);
  assign out_valid  = (state_reg == EMIT);
  assign busy       = (state_reg != IDLE) && (state_reg != ERR);

  always_comb begin
    case (state_reg)
      CODE:                     axiir = !matched && !overrun;
      XLIN, XSIGN, YLIN, YSIGN: axiir = 1'b1;
      default:                  axiir = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pairs_left_reg <= '0;
      lin_reg        <= '0;
      cnt_reg        <= '0;
      lin_acc_reg    <= '0;
      x_mag_reg      <= '0;
      y_mag_reg      <= '0;
      x_neg_reg      <= 1'b0;
      lut_bits       <= '0;
      lut_len        <= '0;
      x_val          <= '0;
      y_val          <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, ERR: begin
          if (start) begin
            pairs_left_reg <= num_pairs;
            lin_reg        <= (linbits > 4'(MAX_LINBITS)) ? 4'(MAX_LINBITS) : linbits;
            lut_bits       <= '0;
            lut_len        <= '0;
            err            <= 1'b0;
            if (num_pairs == 10'd0) begin
              state_reg <= IDLE;
              done      <= 1'b1;
            end else begin
              state_reg <= CODE;
            end
          end
        end
        CODE: begin
          if (matched) begin
            x_mag_reg   <= MAG_W'(lut_x);
            y_mag_reg   <= MAG_W'(lut_y);
            x_neg_reg   <= 1'b0;
            cnt_reg     <= lin_reg;
            lin_acc_reg <= '0;
            state_reg   <= code_route;
            if (code_route == EMIT) begin
              x_val <= '0;
              y_val <= '0;
            end
          end else if (overrun) begin
            state_reg <= ERR;
            err       <= 1'b1;
          end else if (take) begin
            lut_bits <= {lut_bits[MAX_BITS-2:0], axiid};
            lut_len  <= lut_len + 5'd1;
          end
        end
        XLIN: begin
          if (take) begin
            lin_acc_reg <= lin_shift;
            cnt_reg     <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
              x_mag_reg <= lin_mag;
              state_reg <= XSIGN;
            end
          end
        end
        XSIGN: begin
          if (take) begin
            x_neg_reg   <= axiid;
            cnt_reg     <= lin_reg;
            lin_acc_reg <= '0;
            state_reg   <= sign_route;
            if (sign_route == EMIT) begin
              x_val <= to_val(x_mag_reg, axiid);
              y_val <= '0;
            end
          end
        end
        YLIN: begin
          if (take) begin
            lin_acc_reg <= lin_shift;
            cnt_reg     <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
              y_mag_reg <= lin_mag;
              state_reg <= YSIGN;
            end
          end
        end
        YSIGN: begin
          if (take) begin
            x_val     <= to_val(x_mag_reg, x_neg_reg);
            y_val     <= to_val(y_mag_reg, axiid);
            state_reg <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pairs_left_reg <= pairs_left_reg - 10'd1;
            if (pairs_left_reg == 10'd1) begin
              state_reg <= IDLE;
              done      <= 1'b1;
            end else begin
              state_reg <= CODE;
              lut_bits  <= '0;
              lut_len   <= '0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/huff_pair_decoder.md
# huff_pair_decoder

Table-agnostic, bit-serial Huffman pair decoder for the MP3 big_values region: consumes the bitstream one bit per handshake, queries an external codebook lookup for the (x,y) magnitudes, then extracts runtime-sized linbits and sign bits. Emits signed (x,y) pairs over a ready/valid handshake with backpressure. Sits between the bit-serial SD/bitstream reader and the requantiser; one instance serves every Huffman table by swapping the lookup module and the `linbits` value.

## Interface
- MAX_BITS, 19, longest codeword length accepted before error
- MAX_LINBITS, 13, largest supported linbits value
- OUT_W, 16, output sample width (signed)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- start  in  1  pulse; begin a region (honoured in IDLE and ERR only)
- num_pairs  in  10  pairs to decode, latched on start
- linbits  in  4  linbits for this region, latched on start (values > MAX_LINBITS are clamped to MAX_LINBITS)
- axiiv  in  1  input bit valid
- axiid  in  1  input bit
- axiir  out  1  input ready; a bit is consumed on axiiv && axiir
- lut_bits  out  MAX_BITS  codeword bits collected so far, newest in LSB
- lut_len  out  5  number of valid bits in lut_bits
- lut_found  in  1  combinational: lut_bits/lut_len is a complete codeword
- lut_x, lut_y  in  4 each  magnitudes for the matched codeword
- out_valid  out  1  pair available
- out_ready  in  1  downstream accepts the pair
- x_val, y_val  out  OUT_W each  signed decoded values
- done  out  1  one-cycle pulse after the last pair handshakes
- err  out  1  sticky; codeword overran MAX_BITS
- busy  out  1  state is neither IDLE nor ERR

## Operation
- States: IDLE, CODE, XLIN, XSIGN, YLIN, YSIGN, EMIT, ERR.
- IDLE, start: latch num_pairs and linbits; clear lut_bits/lut_len; go to CODE. If num_pairs == 0, stay in IDLE and pulse done on the next cycle instead.
- CODE, lut_len ≥ 1 and lut_found: latch x_abs/y_abs; axiir = 0 this cycle, so no bit is consumed. Next state is the first applicable of XLIN, XSIGN, YLIN, YSIGN, EMIT.
- CODE, no match: axiir = 1. Each consumed bit shifts in as {lut_bits, axiid} and increments lut_len. The lookup is ignored while lut_len == 0.
- CODE overrun: lut_len == MAX_BITS with no match → ERR. err is set; axiir = 0.
- XLIN: entered only when x_abs == 15 and linbits > 0.
  - Consumes exactly linbits bits, MSB first, into x_lin.
  - x_mag = 15 + x_lin; otherwise x_mag = x_abs.
- XSIGN: entered only if x_mag ≠ 0. Consumes 1 bit; 1 = negative.
- YLIN, YSIGN: identical rules for y.
- EMIT:
  - x_val = neg ? −x_mag : x_mag, sign-extended to OUT_W. Max magnitude is 15 + 8191 = 8206.
  - A zero magnitude always emits +0.
  - Hold out_valid, x_val and y_val stable until out_ready.
  - On handshake, decrement pairs_left. If it reaches 0 → IDLE and pulse done; else → CODE with lut_bits and lut_len cleared.
- axiir = 1 only in CODE (no match), XLIN, XSIGN, YLIN and YSIGN. It is 0 in IDLE, EMIT and ERR.
- ERR: hold until rst, or until start, which behaves as in IDLE and clears err.
- start outside IDLE/ERR is ignored.

## Timing
- Reset values: state = IDLE; axiir, out_valid, done, err and busy = 0; x_val, y_val, lut_bits and lut_len = 0; all counters = 0.
- rst mid-pair (any state) abandons the pair and returns to reset values on the next edge. No done pulse.
- Lookup is combinational on registered lut_bits/lut_len.
- Latency for a codeword whose last bit is consumed at edge k:
  - found is seen in cycle k+1;
  - the state leaves CODE at edge k+2.
- A lin or sign bit consumed at edge j makes the next state effective at j+1. out_valid is high in the cycle after the final bit is consumed.
- A pair with no lin or sign bits reaches EMIT at edge k+2.
- Bits offered during EMIT or IDLE are not consumed; the upstream holds them.
- x_val and y_val are registered, updated only when entering EMIT.
- done is high for exactly one cycle, the cycle after the final handshake.

## Test plan
- Table-6 model, linbits=0, num_pairs=1, bits 1,0,0,1 ("10" → (1,1), signs 0,1) → x=1, y=−1; done pulses once; exactly 4 bits consumed.
- Table-6 model, bits 1,1,1 ("111" → (0,0)) → no sign bits consumed; x=0, y=0; out_valid in the second cycle after the third bit.
- Model with "1" → (15,0), linbits=3, bits 1,1,0,1,1 → x_lin=5, sign=1; x=−20, y=0; exactly 5 bits consumed.
- num_pairs=3 with out_ready low for 5 cycles on the second pair → x_val/y_val held, axiir=0 throughout the stall, all 3 pairs emitted in order, done after the third.
- Model with no match for all-zero input, 19 zero bits → err=1, axiir=0, no out_valid; then start with num_pairs=0 → err clears, done pulses.
- rst asserted in XLIN mid-region → all outputs at reset values next cycle; a new start decodes correctly.
